// File: rtl/bip_halt_reporter_pkg.sv
// Shared constants for the BIP halt reporter: opcodes, frame header, FSM encoding
// and the frame geometry derived from the default datapath widths.
package bip_halt_reporter_pkg;

    // BIP instruction set opcodes, held in the instruction MSBs.
    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    function automatic int bytes_for(input int nbits, input int nb_byte);
        return (nbits + nb_byte - 1) / nb_byte;
    endfunction

    localparam int PC_BYTES_DEF  = bytes_for(11, 8);
    localparam int ACC_BYTES_DEF = bytes_for(16, 8);
    localparam int CNT_BYTES_DEF = bytes_for(32, 8);
    localparam int FRAME_LEN_DEF = 1 + PC_BYTES_DEF + ACC_BYTES_DEF + CNT_BYTES_DEF;

endpackage

// File: rtl/bip_halt_reporter_sat_cycle_counter.sv
// Free-running cycle counter that sticks at all-ones instead of wrapping; also
// exposes the saturated next value so a capture on the same edge includes it.
module bip_halt_reporter_sat_cycle_counter #(
    parameter int NB_CYCLES = 32
) (
    input  logic                 i_clk,
    input  logic                 i_clr,
    input  logic                 i_en,
    output logic [NB_CYCLES-1:0] o_count_next
);

    logic [NB_CYCLES-1:0] count;

    assign o_count_next = (&count) ? count : count + NB_CYCLES'(1);

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            count <= '0;
        end else if (i_en) begin
            count <= o_count_next;
        end
    end

endmodule

// File: rtl/bip_halt_reporter.sv
// BIP halt reporter: freezes the CPU on HALT and sends PC, ACC and cycle count
// to the UART transmitter as a header-prefixed, MSB-first byte frame.
module bip_halt_reporter
    import bip_halt_reporter_pkg::*;
#(
    parameter int                   NB_INSTRUC  = 16,
    parameter int                   NB_OPCODE   = 5,
    parameter int                   NB_ADDR     = 11,
    parameter int                   NB_DATA     = 16,
    parameter int                   NB_CYCLES   = 32,
    parameter int                   NB_BYTE     = 8,
    parameter logic [NB_OPCODE-1:0] HALT_OPCODE = NB_OPCODE'(OP_HLT),
    parameter logic [NB_BYTE-1:0]   HEADER      = NB_BYTE'(FRAME_HEADER)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NB_INSTRUC-1:0] i_instruc,
    input  logic [NB_ADDR-1:0]    i_addr_program_mem,
    input  logic [NB_DATA-1:0]    i_acc,
    input  logic                  i_tx_done,
    output logic                  o_cpu_en,
    output logic                  o_tx_start,
    output logic [NB_BYTE-1:0]    o_tx_data,
    output logic                  o_done
);

    localparam int PC_BYTES  = bytes_for(NB_ADDR, NB_BYTE);
    localparam int ACC_BYTES = bytes_for(NB_DATA, NB_BYTE);
    localparam int CNT_BYTES = bytes_for(NB_CYCLES, NB_BYTE);
    localparam int PC_W      = PC_BYTES * NB_BYTE;
    localparam int ACC_W     = ACC_BYTES * NB_BYTE;
    localparam int CNT_W     = CNT_BYTES * NB_BYTE;
    localparam int FRAME_LEN = 1 + PC_BYTES + ACC_BYTES + CNT_BYTES;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t               state, state_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [NB_ADDR-1:0]   cap_pc, cap_pc_next;
    logic [NB_DATA-1:0]   cap_acc, cap_acc_next;
    logic [NB_CYCLES-1:0] cap_cnt, cap_cnt_next;
    logic [NB_CYCLES-1:0] count_next;
    logic                 halt_seen;
    logic                 unused_operand;

    logic                 tx_start_d;
    logic [NB_BYTE-1:0]   tx_data_d;
    logic                 cpu_en_d;
    logic                 done_d;

    logic [PC_W-1:0]                   pc_ext;
    logic [ACC_W-1:0]                  acc_ext;
    logic [CNT_W-1:0]                  cnt_ext;
    logic [FRAME_LEN-1:0][NB_BYTE-1:0] frame_next;

    assign halt_seen      = (i_instruc[NB_INSTRUC-1 -: NB_OPCODE] == HALT_OPCODE);
    assign unused_operand = ^i_instruc[NB_INSTRUC-NB_OPCODE-1:0];

    bip_halt_reporter_sat_cycle_counter #(
        .NB_CYCLES (NB_CYCLES)
    ) u_sat_cycle_counter (
        .i_clk        (i_clk),
        .i_clr        (i_rst),
        .i_en         (state == ST_RUN),
        .o_count_next (count_next)
    );

    // Frame is built from the values being captured this edge, so the first
    // byte can be registered on the HALT edge itself; element FRAME_LEN-1 goes first.
    assign pc_ext     = PC_W'(cap_pc_next);
    assign acc_ext    = ACC_W'(cap_acc_next);
    assign cnt_ext    = CNT_W'(cap_cnt_next);
    assign frame_next = {HEADER, pc_ext, acc_ext, cnt_ext};

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_RUN;
            idx        <= '0;
            cap_pc     <= '0;
            cap_acc    <= '0;
            cap_cnt    <= '0;
            o_cpu_en   <= 1'b1;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_done     <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            cap_pc     <= cap_pc_next;
            cap_acc    <= cap_acc_next;
            cap_cnt    <= cap_cnt_next;
            o_cpu_en   <= cpu_en_d;
            o_tx_start <= tx_start_d;
            o_tx_data  <= tx_data_d;
            o_done     <= done_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        cap_pc_next  = cap_pc;
        cap_acc_next = cap_acc;
        cap_cnt_next = cap_cnt;
        case (state)
            ST_RUN: begin
                if (halt_seen) begin
                    state_next   = ST_START;
                    idx_next     = '0;
                    cap_pc_next  = i_addr_program_mem;
                    cap_acc_next = i_acc;
                    cap_cnt_next = count_next;
                end
            end
            ST_START: state_next = ST_WAIT;
            ST_WAIT: begin
                if (i_tx_done) begin
                    if (idx == LAST_IDX) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_START;
                        idx_next   = idx + IDX_W'(1);
                    end
                end
            end
            ST_DONE: state_next = ST_DONE;
            default: state_next = ST_RUN;
        endcase
    end

    // Outputs are registered, so they are decoded from the upcoming state.
    always_comb begin
        tx_start_d = (state_next == ST_START);
        cpu_en_d   = (state_next == ST_RUN);
        done_d     = (state_next == ST_DONE);
        tx_data_d  = o_tx_data;
        if (state_next == ST_START) begin
            tx_data_d = frame_next[LAST_IDX - idx_next];
        end
    end

endmodule

// File: tb/tb_bip_halt_reporter.sv
// Directed bench for bip_halt_reporter: default-width frame checks plus a
// 4-bit cycle counter instance for the saturation case.
module tb_bip_halt_reporter;

    localparam logic [15:0] NOP  = 16'h1800;
    localparam logic [15:0] NOP2 = 16'h0800;
    localparam logic [15:0] HLT  = 16'h0123;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst4 = 1'b1;
    logic [15:0] instruc = NOP;
    logic [10:0] addr = '0;
    logic [15:0] acc = '0;
    logic        tx_done = 1'b0;
    logic        tx_done4 = 1'b0;

    logic       cpu_en, tx_start, done;
    logic [7:0] tx_data;
    logic       cpu_en4, tx_start4, done4;
    logic [7:0] tx_data4;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_frame [0:8];
    logic [7:0] exp4 [0:5];

    always #5 clk = ~clk;

    bip_halt_reporter dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_instruc          (instruc),
        .i_addr_program_mem (addr),
        .i_acc              (acc),
        .i_tx_done          (tx_done),
        .o_cpu_en           (cpu_en),
        .o_tx_start         (tx_start),
        .o_tx_data          (tx_data),
        .o_done             (done)
    );

    bip_halt_reporter #(
        .NB_CYCLES (4)
    ) dut4 (
        .i_clk              (clk),
        .i_rst              (rst4),
        .i_instruc          (instruc),
        .i_addr_program_mem (addr),
        .i_acc              (acc),
        .i_tx_done          (tx_done4),
        .o_cpu_en           (cpu_en4),
        .o_tx_start         (tx_start4),
        .o_tx_data          (tx_data4),
        .o_done             (done4)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
            $error("%s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset is held with a HALT and tx_done present to show reset wins.
    task automatic reset_main();
        rst     = 1'b1;
        instruc = HLT;
        tx_done = 1'b1;
        step();
        step();
        check("rst_cpu_en", cpu_en, 1);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_done", done, 0);
        rst     = 1'b0;
        instruc = NOP;
        tx_done = 1'b0;
    endtask

    task automatic run_to_halt(input int n_run, input int halt_pc, input logic [15:0] acc_val);
        for (int i = 0; i < n_run; i++) begin
            addr    = 11'(i);
            instruc = (i % 2 == 0) ? NOP : NOP2;
            step();
            check($sformatf("run_cpu_en_%0d", i), cpu_en, 1);
            check($sformatf("run_start_%0d", i), tx_start, 0);
        end
        addr    = 11'(halt_pc);
        acc     = acc_val;
        instruc = HLT;
        step();
        instruc = NOP;
    endtask

    task automatic set_frame(input logic [15:0] pc, input logic [15:0] a, input logic [31:0] cnt);
        exp_frame[0] = 8'hA5;
        exp_frame[1] = pc[15:8];
        exp_frame[2] = pc[7:0];
        exp_frame[3] = a[15:8];
        exp_frame[4] = a[7:0];
        exp_frame[5] = cnt[31:24];
        exp_frame[6] = cnt[23:16];
        exp_frame[7] = cnt[15:8];
        exp_frame[8] = cnt[7:0];
    endtask

    task automatic recv_bytes(input int delay, input int n);
        for (int k = 0; k < n; k++) begin
            check($sformatf("start_b%0d", k), tx_start, 1);
            check($sformatf("data_b%0d", k), tx_data, exp_frame[k]);
            check($sformatf("cpu_en_b%0d", k), cpu_en, 0);
            check($sformatf("done_b%0d", k), done, 0);
            step();
            check($sformatf("wait_start_b%0d", k), tx_start, 0);
            check($sformatf("wait_data_b%0d", k), tx_data, exp_frame[k]);
            for (int j = 0; j < delay; j++) begin
                step();
                check($sformatf("hold_start_b%0d_%0d", k, j), tx_start, 0);
                check($sformatf("hold_data_b%0d_%0d", k, j), tx_data, exp_frame[k]);
            end
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
        end
    endtask

    initial begin
        // 1: done one cycle after each start
        reset_main();
        set_frame(16'd5, 16'h1234, 32'd6);
        run_to_halt(5, 5, 16'h1234);
        check("t1_cpu_en_after_halt", cpu_en, 0);
        recv_bytes(0, 9);
        check("t1_done", done, 1);
        check("t1_cpu_en", cpu_en, 0);
        check("t1_no_start", tx_start, 0);

        // 2: done delayed 10 cycles per byte
        reset_main();
        run_to_halt(5, 5, 16'h1234);
        recv_bytes(10, 9);
        check("t2_done", done, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t2_idle_start_%0d", i), tx_start, 0);
        end

        // 3: done held high throughout
        reset_main();
        tx_done = 1'b1;
        run_to_halt(5, 5, 16'h1234);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("t3_start_b%0d", k), tx_start, 1);
            check($sformatf("t3_data_b%0d", k), tx_data, exp_frame[k]);
            step();
            check($sformatf("t3_wait_b%0d", k), tx_start, 0);
            step();
        end
        check("t3_done", done, 1);
        tx_done = 1'b0;

        // 4: reset after the third byte, then HALT right after release
        reset_main();
        run_to_halt(5, 5, 16'h1234);
        recv_bytes(0, 3);
        check("t4_start_b3", tx_start, 1);
        check("t4_data_b3", tx_data, 8'h12);
        rst = 1'b1;
        step();
        check("t4_rst_start", tx_start, 0);
        check("t4_rst_cpu_en", cpu_en, 1);
        check("t4_rst_data", tx_data, 0);
        check("t4_rst_done", done, 0);
        rst     = 1'b0;
        addr    = 11'd7;
        acc     = 16'hBEEF;
        instruc = HLT;
        step();
        instruc = NOP;
        set_frame(16'd7, 16'hBEEF, 32'd1);
        recv_bytes(0, 9);
        check("t4_done", done, 1);

        // 6: DONE is sticky against HALTs and done pulses
        for (int i = 0; i < 8; i++) begin
            instruc = HLT;
            tx_done = (i % 2 == 0);
            step();
            check($sformatf("t6_start_%0d", i), tx_start, 0);
            check($sformatf("t6_done_%0d", i), done, 1);
            check($sformatf("t6_cpu_en_%0d", i), cpu_en, 0);
        end
        tx_done = 1'b0;
        instruc = NOP;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("t6_post_rst_done", done, 0);
        check("t6_post_rst_cpu_en", cpu_en, 1);

        // 5: 4-bit counter saturates at 0F, frame is 6 bytes
        rst = 1'b1;
        instruc = NOP;
        step();
        rst4 = 1'b0;
        exp4[0] = 8'hA5;
        exp4[1] = 8'h00;
        exp4[2] = 8'h14;
        exp4[3] = 8'hCA;
        exp4[4] = 8'hFE;
        exp4[5] = 8'h0F;
        check("t5_cpu_en_run", cpu_en4, 1);
        run_to_halt(20, 20, 16'hCAFE);
        check("t5_cpu_en_halt", cpu_en4, 0);
        tx_done4 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t5_start_b%0d", k), tx_start4, 1);
            check($sformatf("t5_data_b%0d", k), tx_data4, exp4[k]);
            check($sformatf("t5_done_b%0d", k), done4, 0);
            step();
            check($sformatf("t5_wait_b%0d", k), tx_start4, 0);
            step();
        end
        check("t5_done", done4, 1);
        check("t5_no_start", tx_start4, 0);
        tx_done4 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
